// File: rtl/strategy_cmp_if.sv
// Handshake and parameter-RAM signals between the feed decoder, RAM control block,
// strategy comparator and order encoder. slave = comparator side.
interface strategy_cmp_if #(
  parameter int ADDR_W  = 14,
  parameter int PARAM_W = 64,
  parameter int PRICE_W = 32
);
  logic               msg_valid;
  logic               msg_ready;
  logic [ADDR_W-1:0]  msg_sym_idx;
  logic [PRICE_W-1:0] msg_price;
  logic [ADDR_W-1:0]  t2t_rd_addr;
  logic               sef_read;
  logic [PARAM_W-1:0] rcb_data;
  logic               ord_valid;
  logic               ord_ready;
  logic [ADDR_W-1:0]  ord_sym_idx;
  logic [PRICE_W-1:0] ord_price;
  logic [15:0]        ord_qty;
  logic               ord_side;

  modport master (
    output msg_valid, msg_sym_idx, msg_price, rcb_data, ord_ready,
    input  msg_ready, t2t_rd_addr, sef_read,
    input  ord_valid, ord_sym_idx, ord_price, ord_qty, ord_side
  );

  modport slave (
    input  msg_valid, msg_sym_idx, msg_price, rcb_data, ord_ready,
    output msg_ready, t2t_rd_addr, sef_read,
    output ord_valid, ord_sym_idx, ord_price, ord_qty, ord_side
  );
endinterface

// File: rtl/strategy_cmp.sv
// Strategy comparator: per-symbol parameter read, price-vs-threshold trigger, order FIFO.
// Optional statistics counters are enabled with `define STRATEGY_CMP_STATS_EN.
module strategy_cmp #(
  parameter int ADDR_W     = 14,
  parameter int PARAM_W    = 64,
  parameter int PRICE_W    = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  strategy_cmp_if.slave bus
`ifdef STRATEGY_CMP_STATS_EN
  ,
  output logic [31:0] stat_msg_cnt,
  output logic [31:0] stat_trig_cnt,
  output logic [31:0] stat_drop_cnt
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W:0]   DEPTH_X = (CNT_W + 1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0]  sym;
    logic [PRICE_W-1:0] price;
    logic [15:0]        qty;
    logic               side;
  } ord_t;

  ord_t               fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               s1_valid;
  logic [ADDR_W-1:0]  s1_sym_idx;
  logic [PRICE_W-1:0] s1_price;

  logic               accept;
  logic               push;
  logic               pop;
  logic               trig;
  logic [CNT_W:0]     credit_used;
  logic [PRICE_W-1:0] p_thresh;
  logic [15:0]        p_qty;
  logic               p_en;
  logic               p_side;
  ord_t               head;
  logic               unused_rsvd;

  // In-flight stage-1 entry reserves a slot so its push can never overflow.
  assign credit_used   = {1'b0, count} + {{CNT_W{1'b0}}, s1_valid};
  assign bus.msg_ready = reset_n && (credit_used < DEPTH_X);
  assign accept        = bus.msg_valid && bus.msg_ready;
  assign bus.sef_read  = accept;
  assign bus.t2t_rd_addr = bus.msg_sym_idx;

  assign p_thresh    = bus.rcb_data[31:0];
  assign p_qty       = bus.rcb_data[47:32];
  assign p_en        = bus.rcb_data[48];
  assign p_side      = bus.rcb_data[49];
  assign unused_rsvd = ^bus.rcb_data[PARAM_W-1:50];

  always_comb begin
    trig = 1'b0;
    if (p_en) begin
      if (p_side) trig = (s1_price >= p_thresh);
      else        trig = (s1_price <= p_thresh);
    end
  end

  assign push = s1_valid && trig;
  assign pop  = bus.ord_valid && bus.ord_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      s1_valid <= accept;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_sym_idx <= bus.msg_sym_idx;
      s1_price   <= bus.msg_price;
    end
    if (push) fifo_mem[wr_ptr] <= '{sym: s1_sym_idx, price: s1_price, qty: p_qty, side: p_side};
  end

  always_ff @(posedge clk) begin
    if (reset_n && push) assert (count != DEPTH_C);
  end

  assign head            = fifo_mem[rd_ptr];
  assign bus.ord_valid   = (count != '0);
  assign bus.ord_sym_idx = head.sym;
  assign bus.ord_price   = head.price;
  assign bus.ord_qty     = head.qty;
  assign bus.ord_side    = head.side;

`ifdef STRATEGY_CMP_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stat_msg_cnt  <= '0;
      stat_trig_cnt <= '0;
      stat_drop_cnt <= '0;
    end else begin
      if (accept && stat_msg_cnt != '1)  stat_msg_cnt  <= stat_msg_cnt + 32'd1;
      if (push && stat_trig_cnt != '1)   stat_trig_cnt <= stat_trig_cnt + 32'd1;
      if (s1_valid && !trig && stat_drop_cnt != '1) stat_drop_cnt <= stat_drop_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_strategy_cmp.sv
// Scoreboard bench for strategy_cmp: directed messages push expected orders,
// an independent monitor pops and compares whenever an order is consumed.
module tb_strategy_cmp;
  localparam int ADDR_W = 14, PARAM_W = 64, PRICE_W = 32, FIFO_DEPTH = 4;

  typedef struct packed {
    logic [13:0] sym;
    logic [31:0] price;
    logic [15:0] qty;
    logic        side;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  strategy_cmp_if #(.ADDR_W(ADDR_W), .PARAM_W(PARAM_W), .PRICE_W(PRICE_W)) bus ();

`ifdef STRATEGY_CMP_STATS_EN
  logic [31:0] stat_msg_cnt, stat_trig_cnt, stat_drop_cnt;
`endif

  strategy_cmp #(.ADDR_W(ADDR_W), .PARAM_W(PARAM_W), .PRICE_W(PRICE_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus.slave)
`ifdef STRATEGY_CMP_STATS_EN
    ,
    .stat_msg_cnt(stat_msg_cnt),
    .stat_trig_cnt(stat_trig_cnt),
    .stat_drop_cnt(stat_drop_cnt)
`endif
  );

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic [63:0] param_mem [0:15];

  // Registered parameter RAM; data is zero (disabled) when no read was issued.
  always @(posedge clk) begin
    if (bus.sef_read && bus.t2t_rd_addr < 14'd16) bus.rcb_data <= param_mem[bus.t2t_rd_addr[3:0]];
    else                                          bus.rcb_data <= '0;
  end

  function automatic logic [63:0] mk(bit en, bit side, logic [15:0] qty, logic [31:0] th, logic [13:0] rsvd);
    return {rsvd, side, en, qty, th};
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  exp_t cur, prev, e;
  bit   held = 0;

  always @(negedge clk) begin
    #2;
    if (!reset_n) held = 0;
    else begin
      cur = {bus.ord_sym_idx, bus.ord_price, bus.ord_qty, bus.ord_side};
      if (held) begin
        chk("hold_valid", 64'(bus.ord_valid), 64'd1);
        chk("hold_data", 64'(cur), 64'(prev));
      end
      if (bus.ord_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_order: got sym %0d price %0d, expected no order", cur.sym, cur.price);
        end else if (bus.ord_ready) begin
          e = exp_q.pop_front();
          chk("order", 64'(cur), 64'(e));
        end
        held = !bus.ord_ready;
        prev = cur;
      end else held = 0;
    end
  end

  // Starts at a falling edge; returns at the falling edge after the accept edge.
  task automatic send(input logic [13:0] sym, input logic [31:0] price, input bit trig,
                      input logic [15:0] qty, input bit side);
    int waited = 0;
    bus.msg_valid   = 1'b1;
    bus.msg_sym_idx = sym;
    bus.msg_price   = price;
    #1;
    while (!bus.msg_ready && waited < 50) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!bus.msg_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got msg_ready 0 for sym %0d, expected 1 within 50 cycles", sym);
      return;
    end
    chk("sef_read", 64'(bus.sef_read), 64'd1);
    chk("rd_addr", 64'(bus.t2t_rd_addr), 64'(sym));
    if (trig) exp_q.push_back('{sym: sym, price: price, qty: qty, side: side});
    @(negedge clk);
  endtask

  task automatic wait_empty(string name);
    for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(negedge clk);
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected end before time limit");
    $fatal(1);
  end

  initial begin
    int n_acc;
    foreach (param_mem[i]) param_mem[i] = '0;
    param_mem[5] = mk(1, 0, 16'd100, 32'd1000, 14'd0);
    param_mem[6] = mk(0, 0, 16'd55, 32'd1000, 14'd0);
    param_mem[7] = mk(1, 1, 16'd7, 32'd500, 14'h3FFF);
    param_mem[8] = mk(1, 0, 16'd42, 32'd5000, 14'd0);

    bus.msg_valid   = 1'b1;
    bus.msg_sym_idx = 14'd5;
    bus.msg_price   = 32'd0;
    bus.ord_ready   = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_msg_ready", 64'(bus.msg_ready), 64'd0);
    chk("rst_sef_read", 64'(bus.sef_read), 64'd0);
    chk("rst_ord_valid", 64'(bus.ord_valid), 64'd0);
    bus.msg_valid = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    #1 chk("ready_after_rst", 64'(bus.msg_ready), 64'd1);
`ifdef STRATEGY_CMP_STATS_EN
    chk("stat_rst", {stat_msg_cnt, stat_drop_cnt}, 64'd0);
`endif

    // single trigger: accept in N, order visible in N+2
    @(negedge clk);
    send(14'd5, 32'd999, 1, 16'd100, 0);
    bus.msg_valid = 1'b0;
    #1 chk("lat_n1_idle", 64'(bus.ord_valid), 64'd0);
    @(negedge clk);
    #1 chk("lat_n2_valid", 64'(bus.ord_valid), 64'd1);
    chk("lat_n2_price", 64'(bus.ord_price), 64'd999);

    // non-trigger and disabled symbol
    @(negedge clk);
    send(14'd5, 32'd1001, 0, 16'd0, 0);
    send(14'd6, 32'd0, 0, 16'd0, 0);
    bus.msg_valid = 1'b0;
    repeat (4) @(negedge clk);
`ifdef STRATEGY_CMP_STATS_EN
    #1;
    chk("stat_msg", 64'(stat_msg_cnt), 64'd3);
    chk("stat_trig", 64'(stat_trig_cnt), 64'd1);
    chk("stat_drop", 64'(stat_drop_cnt), 64'd2);
`endif

    // sell boundary, back-to-back
    send(14'd7, 32'd499, 0, 16'd0, 0);
    send(14'd7, 32'd500, 1, 16'd7, 1);
    send(14'd7, 32'd501, 1, 16'd7, 1);
    bus.msg_valid = 1'b0;
    #1 chk("sell_first", {31'd0, bus.ord_valid, bus.ord_price}, {31'd0, 1'b1, 32'd500});
    @(negedge clk);
    #1 chk("sell_second", {31'd0, bus.ord_valid, bus.ord_price}, {31'd0, 1'b1, 32'd501});
    @(negedge clk);
    #1 chk("sell_done", 64'(bus.ord_valid), 64'd0);

    // backpressure: four accepts then stall
    @(negedge clk);
    bus.ord_ready   = 1'b0;
    n_acc           = 0;
    bus.msg_valid   = 1'b1;
    bus.msg_sym_idx = 14'd8;
    for (int c = 0; c < 10; c++) begin
      bus.msg_price = 32'(100 + n_acc);
      #1;
      if (bus.msg_ready) begin
        exp_q.push_back('{sym: 14'd8, price: 32'(100 + n_acc), qty: 16'd42, side: 1'b0});
        n_acc++;
      end
      @(negedge clk);
    end
    chk("bp_accepts", 64'(n_acc), 64'd4);
    chk("bp_ready_low", 64'(bus.msg_ready), 64'd0);
    bus.ord_ready = 1'b1;
    send(14'd8, 32'd104, 1, 16'd42, 0);
    send(14'd8, 32'd105, 1, 16'd42, 0);
    bus.msg_valid = 1'b0;
    wait_empty("bp_drain");

    // simultaneous push and pop with two queued
    bus.ord_ready = 1'b0;
    send(14'd8, 32'd200, 1, 16'd42, 0);
    send(14'd8, 32'd201, 1, 16'd42, 0);
    send(14'd8, 32'd202, 1, 16'd42, 0);
    bus.msg_valid = 1'b0;
    bus.ord_ready = 1'b1;
    #1;
    chk("pp_ready", 64'(bus.msg_ready), 64'd1);
    chk("pp_head0", 64'(bus.ord_price), 64'd200);
    @(negedge clk);
    bus.ord_ready = 1'b0;
    #1;
    chk("pp_ready_after", 64'(bus.msg_ready), 64'd1);
    chk("pp_head1", {31'd0, bus.ord_valid, bus.ord_price}, {31'd0, 1'b1, 32'd201});
    @(negedge clk);
    bus.ord_ready = 1'b1;
    wait_empty("pp_drain");

    // reset with three queued and one in stage 1
    bus.ord_ready = 1'b0;
    for (int k = 0; k < 4; k++) send(14'd8, 32'(300 + k), 1, 16'd42, 0);
    reset_n       = 1'b0;
    bus.msg_valid = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(bus.ord_valid), 64'd0);
    chk("mid_rst_ready", 64'(bus.msg_ready), 64'd1);
`ifdef STRATEGY_CMP_STATS_EN
    chk("mid_rst_stat", 64'(stat_trig_cnt), 64'd0);
`endif
    bus.ord_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1 chk("no_stale", 64'(bus.ord_valid), 64'd0);
    end
    @(negedge clk);
    send(14'd5, 32'd10, 1, 16'd100, 0);
    bus.msg_valid = 1'b0;
    wait_empty("post_rst_drain");

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
